adc_spi_capture: RTL and testbench
==================================

// Module: adc_spi_capture
// PURPOSE
//  Parametrised SPI master for MCP320x-family serial ADCs (mode 0,0, read-only).
//  Generates adc_cs_n/adc_sclk from clk_adc, shifts in one conversion frame MSB first,
//  strips the leading sample/null bits, and publishes the result on a valid/ready port
//  to the serial TX block. Supports single-shot and continuous conversion.
// PARAMETERS
//  DATA_BITS    12  result width, >= 8
//  LEAD_BITS     3  SCLK cycles before data MSB; the last lead bit is the null bit
//  CLK_DIV       2  clk_adc cycles per SCLK half-period, >= 1
//  CS_HIGH_CYC   8  minimum clk_adc cycles adc_cs_n stays high between frames, >= 1
// PORTS
//  clk_adc       in   1          system clock; all logic is on the rising edge
//  reset         in   1          asynchronous, active-high
//  start         in   1          single-shot request, 1-cycle pulse, sampled in IDLE
//  continuous    in   1          level; while 1, back-to-back frames
//  adc_dout      in   1          ADC serial data out (MISO)
//  adc_cs_n      out  1          ADC chip select, active-low
//  adc_sclk      out  1          ADC serial clock, idles low
//  sample_data   out  DATA_BITS  last converted result
//  sample_byte   out  8          sample_data[DATA_BITS-1 -: 8], top 8 bits
//  sample_valid  out  1          sample_data holds an unconsumed result
//  sample_ready  in   1          consumer accepts when sample_valid & sample_ready
//  busy          out  1          1 in every state except IDLE
//  overrun       out  1          sticky: an unconsumed result was overwritten
//  frame_err     out  1          sticky: null bit sampled as 1
// BEHAVIOUR
//  Reset (async, mid-frame included): adc_cs_n=1, adc_sclk=0, sample_data=0, sample_valid=0,
//   busy=0, overrun=0, frame_err=0, FSM=IDLE. Any partial frame is discarded.
//  TOTAL = LEAD_BITS + DATA_BITS SCLK periods per frame.
//  FSM:
//   IDLE:    start=1 or continuous=1 -> CS_SETUP next cycle. adc_cs_n=1, adc_sclk=0.
//   CS_SETUP: adc_cs_n=0, adc_sclk=0 for CLK_DIV cycles -> SHIFT.
//   SHIFT:   half-period counter 0..CLK_DIV-1; on each wrap, toggle adc_sclk.
//            On the edge driving adc_sclk 0->1, shift adc_dout into the shift register.
//            After the TOTAL-th falling edge -> CS_HOLD.
//            adc_cs_n is low for exactly CLK_DIV*(1+2*TOTAL) cycles.
//   CS_HOLD: adc_cs_n=1, adc_sclk=0 for CS_HIGH_CYC cycles, then:
//            continuous=1 -> CS_SETUP; otherwise -> IDLE.
//  start is ignored outside IDLE. Clearing continuous mid-frame completes the current frame.
//  Publish: in the cycle the FSM enters CS_HOLD:
//   - sample_data <= low DATA_BITS of the shift register; sample_valid <= 1.
//   - Null bit = shift bit index DATA_BITS. If 1, set frame_err; data is still published.
//  Handshake: sample_valid drops the cycle after (sample_valid & sample_ready)
//   unless a publish occurs in that same cycle.
//  Simultaneous publish and accept: the new data loads, sample_valid stays 1, no overrun.
//  Publish while sample_valid=1 and no accept: data overwritten; overrun <= 1 (sticky to reset).
//  sample_data and sample_byte are stable while sample_valid=1 except on an overwrite.
// TESTING
//  1. Defaults, ADC model returns lead 2'bxx,0 then 12'hA5C on start pulse
//     -> sample_data=12'hA5C, sample_byte=8'hA5, 15 SCLK rises, adc_cs_n low 62 cycles,
//        sample_valid=1.
//  2. continuous=1, sample_ready=1, model values 1,2,3
//     -> three results in order; adc_cs_n high exactly 8 cycles between frames; overrun=0.
//  3. continuous=1, sample_ready=0 for two frames
//     -> second frame overwrites the first, overrun=1 and stays 1; sample_valid=1.
//  4. Null bit driven 1 -> frame_err=1, data still published.
//     start pulse while busy -> ignored; no extra frame.
//  5. reset asserted mid-SHIFT (bit 6)
//     -> adc_cs_n=1 and adc_sclk=0 immediately; all outputs 0;
//        next start yields a clean full frame.
//  6. Params DATA_BITS=10, LEAD_BITS=5, CLK_DIV=1, model 10'h3FF
//     -> sample_data=10'h3FF, sample_byte=8'hFF, 15 SCLK rises.

Source files
------------

// File: rtl/adc_spi_capture.sv
// SPI master for MCP320x-family ADCs (mode 0,0, read-only).
// It captures one frame MSB first and publishes the result on a valid/ready port.
module adc_spi_capture #(
  parameter int DATA_BITS   = 12,
  parameter int LEAD_BITS   = 3,
  parameter int CLK_DIV     = 2,
  parameter int CS_HIGH_CYC = 8
) (
  input  logic                 clk_adc,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 adc_dout,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic [DATA_BITS-1:0] sample_data,
  output logic [7:0]           sample_byte,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 busy,
  output logic                 overrun,
  output logic                 frame_err
);

  localparam int TOTAL  = LEAD_BITS + DATA_BITS;
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int HOLD_W = $clog2(CS_HIGH_CYC + 1);
  localparam int EDGE_W = $clog2(2 * TOTAL + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HIGH_CYC - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CS_SETUP = 2'd1,
    S_SHIFT    = 2'd2,
    S_CS_HOLD  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [EDGE_W-1:0]    r_edge_cnt;
  logic [DATA_BITS:0]   r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_cs_n;
  logic                 r_sclk;
  logic                 r_busy;
  logic                 r_valid;
  logic                 r_overrun;
  logic                 r_frame_err;
  logic                 w_div_wrap;
  logic                 w_publish;
  logic                 w_accept;

  assign w_div_wrap = (r_div_cnt == DIV_LAST);
  assign w_accept   = r_valid & sample_ready;
  assign w_publish  = (r_state == S_SHIFT) && (w_next == S_CS_HOLD);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start || continuous) w_next = S_CS_SETUP;
        else                     w_next = S_IDLE;
      end
      S_CS_SETUP: begin
        if (w_div_wrap) w_next = S_SHIFT;
        else            w_next = S_CS_SETUP;
      end
      S_SHIFT: begin
        // The final half-period wrap is always a falling SCLK edge.
        if (w_div_wrap && (r_edge_cnt == EDGE_LAST)) w_next = S_CS_HOLD;
        else                                         w_next = S_SHIFT;
      end
      S_CS_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          if (continuous) w_next = S_CS_SETUP;
          else            w_next = S_IDLE;
        end else begin
          w_next = S_CS_HOLD;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register, timing counters and receive shift register
  always_ff @(posedge clk_adc or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_hold_cnt <= '0;
      r_edge_cnt <= '0;
      r_shift    <= '0;
    end else begin
      r_state <= w_next;

      if (((r_state == S_CS_SETUP) || (r_state == S_SHIFT)) && !w_div_wrap)
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      else
        r_div_cnt <= '0;

      if ((r_state == S_CS_HOLD) && (w_next == S_CS_HOLD))
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      else
        r_hold_cnt <= '0;

      if ((r_state == S_SHIFT) && (w_next == S_SHIFT)) begin
        if (w_div_wrap) r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
        else            r_edge_cnt <= r_edge_cnt;
      end else begin
        r_edge_cnt <= '0;
      end

      // Sample MISO on the clock edge that drives SCLK high.
      if ((r_state == S_SHIFT) && w_div_wrap && !r_sclk)
        r_shift <= {r_shift[DATA_BITS-1:0], adc_dout};
      else
        r_shift <= r_shift;
    end
  end

  // Registered SPI pins and busy flag
  always_ff @(posedge clk_adc or posedge reset) begin
    if (reset) begin
      r_cs_n <= 1'b1;
      r_sclk <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_cs_n <= !((w_next == S_CS_SETUP) || (w_next == S_SHIFT));
      r_busy <= (w_next != S_IDLE);
      if ((r_state == S_SHIFT) && w_div_wrap) r_sclk <= ~r_sclk;
      else if (r_state == S_SHIFT)            r_sclk <= r_sclk;
      else                                    r_sclk <= 1'b0;
    end
  end

  // Result publication, handshake and sticky error flags
  always_ff @(posedge clk_adc or posedge reset) begin
    if (reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_publish) begin
        r_data  <= r_shift[DATA_BITS-1:0];
        r_valid <= 1'b1;
        if (r_valid && !sample_ready) r_overrun <= 1'b1;
        else                          r_overrun <= r_overrun;
        if (r_shift[DATA_BITS]) r_frame_err <= 1'b1;
        else                    r_frame_err <= r_frame_err;
      end else begin
        r_data      <= r_data;
        r_overrun   <= r_overrun;
        r_frame_err <= r_frame_err;
        if (w_accept) r_valid <= 1'b0;
        else          r_valid <= r_valid;
      end
    end
  end

  assign adc_cs_n     = r_cs_n;
  assign adc_sclk     = r_sclk;
  assign busy         = r_busy;
  assign sample_data  = r_data;
  assign sample_byte  = r_data[DATA_BITS-1 -: 8];
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Self-checking bench for adc_spi_capture: default-parameter instance plus a
// DATA_BITS=10/LEAD_BITS=5/CLK_DIV=1 instance, each driven by a behavioural ADC.
module tb_adc_spi_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0, continuous = 1'b0, sample_ready = 1'b0;
  logic        adc_dout, adc_cs_n, adc_sclk, sample_valid, busy, overrun, frame_err;
  logic [11:0] sample_data;
  logic [7:0]  sample_byte;

  logic        start6 = 1'b0;
  logic        adc_dout6, cs6, sclk6, valid6, busy6, ovr6, ferr6;
  logic [9:0]  data6;
  logic [7:0]  byte6;

  adc_spi_capture dut (
    .clk_adc(clk), .reset(reset), .start(start), .continuous(continuous),
    .adc_dout(adc_dout), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .sample_data(sample_data), .sample_byte(sample_byte), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .overrun(overrun), .frame_err(frame_err)
  );

  adc_spi_capture #(.DATA_BITS(10), .LEAD_BITS(5), .CLK_DIV(1), .CS_HIGH_CYC(8)) dut6 (
    .clk_adc(clk), .reset(reset), .start(start6), .continuous(1'b0),
    .adc_dout(adc_dout6), .adc_cs_n(cs6), .adc_sclk(sclk6),
    .sample_data(data6), .sample_byte(byte6), .sample_valid(valid6),
    .sample_ready(1'b0), .busy(busy6), .overrun(ovr6), .frame_err(ferr6)
  );

  int checks = 0;
  int errors = 0;

  // ADC model + bus monitor for the default instance: the frame is {lead, data},
  // bit TOTAL-1 presented at CS fall, then one bit per SCLK falling edge.
  logic [14:0] next_frame = 15'd0;
  logic [14:0] cur_frame;
  int bit_idx, hi_cnt, lo_cnt, rise_cnt, last_low, last_gap, last_rises, frames_done;
  logic prev_sclk;
  always @(negedge clk) begin
    if (reset) begin
      hi_cnt = 0; lo_cnt = 0; rise_cnt = 0; last_low = 0; last_gap = 0;
      last_rises = 0; frames_done = 0; prev_sclk = 1'b0; adc_dout = 1'b0;
      bit_idx = 14; cur_frame = 15'd0;
    end else begin
      if (adc_cs_n === 1'b1) begin
        if (lo_cnt != 0) begin
          last_low = lo_cnt; last_rises = rise_cnt; frames_done++;
          lo_cnt = 0; rise_cnt = 0;
        end
        hi_cnt++;
      end else begin
        if (lo_cnt == 0) begin
          last_gap = hi_cnt; hi_cnt = 0; cur_frame = next_frame; bit_idx = 14;
        end else if (prev_sclk && !adc_sclk && bit_idx > 0) begin
          bit_idx--;
        end
        if (adc_sclk && !prev_sclk) rise_cnt++;
        adc_dout = cur_frame[bit_idx];
        lo_cnt++;
      end
      prev_sclk = adc_sclk;
    end
  end

  // Same model for the small-parameter instance.
  logic [14:0] next6 = 15'd0;
  logic [14:0] cur6;
  int idx6, lo6, rise6, last_low6, last_rises6, frames6;
  logic prev6;
  always @(negedge clk) begin
    if (reset) begin
      lo6 = 0; rise6 = 0; last_low6 = 0; last_rises6 = 0; frames6 = 0;
      prev6 = 1'b0; adc_dout6 = 1'b0; idx6 = 14; cur6 = 15'd0;
    end else begin
      if (cs6 === 1'b1) begin
        if (lo6 != 0) begin
          last_low6 = lo6; last_rises6 = rise6; frames6++; lo6 = 0; rise6 = 0;
        end
      end else begin
        if (lo6 == 0) begin
          cur6 = next6; idx6 = 14;
        end else if (prev6 && !sclk6 && idx6 > 0) begin
          idx6--;
        end
        if (sclk6 && !prev6) rise6++;
        adc_dout6 = cur6[idx6];
        lo6++;
      end
      prev6 = sclk6;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (frames_done < target && n < 3000) begin
      tick();
      n++;
    end
    if (frames_done < target) begin
      checks++; errors++;
      $display("FAIL %s timeout frames=%0d required=%0d", name, frames_done, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic consume();
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  lead;
    logic [11:0] data;
    logic [11:0] exp_data;
    logic [7:0]  exp_byte;
  } vec_t;
  vec_t tbl[10];

  int base;
  logic [14:0] fr;

  initial begin
    // Randomised table; reference result is the frame modulo 2^DATA_BITS.
    for (int i = 0; i < 10; i++) begin
      tbl[i].lead = {2'($urandom_range(0, 3)), 1'b0};
      tbl[i].data = 12'($urandom_range(0, 4095));
    end
    tbl[0].data = 12'h000;
    tbl[1].data = 12'hFFF;
    tbl[1].lead = 3'b110;
    for (int i = 0; i < 10; i++) begin
      fr = {tbl[i].lead, tbl[i].data};
      tbl[i].exp_data = 12'(fr % 15'd4096);
      tbl[i].exp_byte = 8'(tbl[i].exp_data / 12'd16);
    end

    repeat (3) @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, adc_sclk}, 32'd0);
    chk("rst_data", {20'd0, sample_data}, 32'd0);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovr_ferr", {30'd0, overrun, frame_err}, 32'd0);

    // Default parameters, single shot 12'hA5C.
    next_frame = {3'b110, 12'hA5C};
    base = frames_done;
    pulse_start();
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    wait_frames(base + 1, "t1_wait");
    chk("t1_data", {20'd0, sample_data}, 32'h0A5C);
    chk("t1_byte", {24'd0, sample_byte}, 32'hA5);
    chk("t1_rises", last_rises, 32'd15);
    chk("t1_cs_low", last_low, 32'd62);
    chk("t1_valid", {31'd0, sample_valid}, 32'd1);
    repeat (3) tick();
    chk("t1_valid_held", {31'd0, sample_valid}, 32'd1);
    consume();
    chk("t1_valid_drop", {31'd0, sample_valid}, 32'd0);
    wait_idle("t1_idle");

    // Table of randomised single-shot frames.
    for (int i = 0; i < 10; i++) begin
      next_frame = {tbl[i].lead, tbl[i].data};
      base = frames_done;
      pulse_start();
      wait_frames(base + 1, "tbl_wait");
      chk($sformatf("tbl%0d_data", i), {20'd0, sample_data}, {20'd0, tbl[i].exp_data});
      chk($sformatf("tbl%0d_byte", i), {24'd0, sample_byte}, {24'd0, tbl[i].exp_byte});
      chk($sformatf("tbl%0d_valid", i), {31'd0, sample_valid}, 32'd1);
      chk($sformatf("tbl%0d_ferr", i), {31'd0, frame_err}, 32'd0);
      consume();
      chk($sformatf("tbl%0d_drop", i), {31'd0, sample_valid}, 32'd0);
      wait_idle("tbl_idle");
    end

    // Continuous with ready held high: results 1,2,3 in order, 8-cycle CS gaps.
    sample_ready = 1'b1;
    next_frame = {3'b000, 12'd1};
    base = frames_done;
    continuous = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_frames(base + k, "cont_wait");
      chk($sformatf("cont%0d_data", k), {20'd0, sample_data}, k);
      chk($sformatf("cont%0d_valid", k), {31'd0, sample_valid}, 32'd1);
      if (k > 1) chk($sformatf("cont%0d_gap", k), last_gap, 32'd8);
      next_frame = {3'b000, 12'(k + 1)};
      if (k == 3) continuous = 1'b0;
    end
    tick();
    chk("cont_valid_drop", {31'd0, sample_valid}, 32'd0);
    wait_idle("cont_idle");
    chk("cont_frames", frames_done, base + 3);
    chk("cont_overrun", {31'd0, overrun}, 32'd0);

    // Continuous with ready low: second frame overwrites the first.
    sample_ready = 1'b0;
    next_frame = {3'b000, 12'h111};
    base = frames_done;
    continuous = 1'b1;
    wait_frames(base + 1, "ovr_wait1");
    chk("ovr_first_data", {20'd0, sample_data}, 32'h111);
    chk("ovr_first_flag", {31'd0, overrun}, 32'd0);
    next_frame = {3'b000, 12'h222};
    wait_frames(base + 2, "ovr_wait2");
    continuous = 1'b0;
    chk("ovr_second_data", {20'd0, sample_data}, 32'h222);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_valid", {31'd0, sample_valid}, 32'd1);
    consume();
    wait_idle("ovr_idle");
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Null bit high sets frame_err; start pulse while busy is ignored.
    next_frame = {3'b001, 12'h5A5};
    base = frames_done;
    pulse_start();
    while (rise_cnt < 3) tick();
    pulse_start();
    wait_frames(base + 1, "ferr_wait");
    chk("ferr_flag", {31'd0, frame_err}, 32'd1);
    chk("ferr_data", {20'd0, sample_data}, 32'h5A5);
    repeat (40) tick();
    chk("busy_start_ignored", frames_done, base + 1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    consume();

    // Asynchronous reset in the middle of data bit shifting.
    next_frame = {3'b000, 12'hFFF};
    pulse_start();
    for (int n = 0; n < 500 && rise_cnt < 6; n++) tick();
    chk("mid_rises", rise_cnt, 32'd6);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
    chk("mid_rst_sclk", {31'd0, adc_sclk}, 32'd0);
    chk("mid_rst_flags", {28'd0, sample_valid, busy, overrun, frame_err}, 32'd0);
    chk("mid_rst_data", {20'd0, sample_data}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    next_frame = {3'b010, 12'h3C3};
    base = frames_done;
    pulse_start();
    wait_frames(base + 1, "post_rst_wait");
    chk("post_rst_data", {20'd0, sample_data}, 32'h3C3);
    chk("post_rst_rises", last_rises, 32'd15);
    chk("post_rst_cs_low", last_low, 32'd62);
    chk("post_rst_ferr", {31'd0, frame_err}, 32'd0);

    // Small-parameter instance: 5 lead bits, 10 data bits, CLK_DIV=1.
    next6 = {5'b11110, 10'h3FF};
    base = frames6;
    @(negedge clk);
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    for (int n = 0; n < 500 && frames6 < base + 1; n++) tick();
    chk("p6_frames", frames6, base + 1);
    chk("p6_data", {22'd0, data6}, 32'h3FF);
    chk("p6_byte", {24'd0, byte6}, 32'hFF);
    chk("p6_rises", last_rises6, 32'd15);
    chk("p6_cs_low", last_low6, 32'd31);
    chk("p6_valid_ferr", {30'd0, valid6, ferr6}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
